// File: rtl/ldpc_rd_pkg.sv
// rtl/ldpc_rd_pkg.sv - shared types and constants for the LDPC read-address sequencer
package ldpc_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } rd_state_t;

    localparam logic [1:0] CYC_NONE = 2'd0;
    localparam logic [1:0] CYC_1    = 2'd1;
    localparam logic [1:0] CYC_2    = 2'd2;
    localparam logic [1:0] CYC_3    = 2'd3;

    // Field positions inside a table entry, counted in units of A_WID bits
    // from the LSB: slice = entry[FLD_x*A_WID +: A_WID].
    localparam int FLD_BASE = 3;
    localparam int FLD_OFF1 = 2;
    localparam int FLD_OFF2 = 1;
    localparam int FLD_OFF3 = 0;

endpackage

// File: rtl/ldpc_rd_prefetch.sv
// rtl/ldpc_rd_prefetch.sv - table read-data capture, shadow register and load mux
module ldpc_rd_prefetch #(
    parameter int D_WID = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tbl_rd,
    input  logic [D_WID-1:0] tbl_data,
    output logic [D_WID-1:0] load_data
);

    logic             rd_vld_d;
    logic [D_WID-1:0] shadow;

    // Track when table data is valid and keep a copy so a stalled consumer never loses it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_d <= 1'b0;
            shadow   <= '0;
        end else begin
            rd_vld_d <= tbl_rd;
            if (rd_vld_d) begin
                shadow <= tbl_data;
            end
        end
    end

    assign load_data = rd_vld_d ? tbl_data : shadow;

endmodule

// File: rtl/ldpc_rd_seq.sv
// rtl/ldpc_rd_seq.sv - parity-check row walker feeding base/offset triples to rd_cell
module ldpc_rd_seq
    import ldpc_rd_pkg::*;
#(
    parameter int A_WID = 8,
    parameter int R_WID = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [R_WID-1:0]   row_num,
    input  logic               stall,
    output logic               tbl_rd,
    output logic [R_WID-1:0]   tbl_addr,
    input  logic [4*A_WID-1:0] tbl_data,
    output logic               en,
    output logic [1:0]         cycle,
    output logic [A_WID-1:0]   base_addr,
    output logic [3*A_WID-1:0] addr_offset,
    output logic [R_WID-1:0]   row_idx,
    output logic               busy,
    output logic               done
);

    rd_state_t              state;
    rd_state_t              state_nxt;
    logic [R_WID-1:0]       num_rows;
    logic [R_WID:0]         row_nxt;
    logic                   more_rows;
    logic                   load;
    logic [4*A_WID-1:0]     load_data;

    // One extra bit so row_idx+1 cannot wrap when row_num is at its maximum.
    assign row_nxt   = {1'b0, row_idx} + {{R_WID{1'b0}}, 1'b1};
    assign more_rows = row_nxt < {1'b0, num_rows};

    ldpc_rd_prefetch #(
        .D_WID (4*A_WID)
    ) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .tbl_rd    (tbl_rd),
        .tbl_data  (tbl_data),
        .load_data (load_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, table strobes and status outputs; stall freezes everything but IDLE/DONE.
    always_comb begin
        state_nxt = state;
        tbl_rd    = 1'b0;
        tbl_addr  = '0;
        en        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (row_num != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                busy = 1'b1;
                if (!stall) begin
                    tbl_rd    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (!stall) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    en = 1'b1;
                    if (cycle == CYC_2 && more_rows) begin
                        tbl_rd   = 1'b1;
                        tbl_addr = row_nxt[R_WID-1:0];
                    end
                    if (cycle == CYC_3) begin
                        if (more_rows) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Working registers: pass length, row index, sub-cycle and the presented entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_rows    <= '0;
            row_idx     <= '0;
            cycle       <= CYC_NONE;
            base_addr   <= '0;
            addr_offset <= '0;
        end else begin
            if (state == ST_IDLE && start && row_num != '0) begin
                num_rows <= row_num;
                row_idx  <= '0;
            end
            if (load) begin
                base_addr   <= load_data[FLD_BASE*A_WID +: A_WID];
                addr_offset <= load_data[FLD_OFF3*A_WID +: 3*A_WID];
                cycle       <= CYC_1;
                if (state == ST_RUN) begin
                    row_idx <= row_nxt[R_WID-1:0];
                end
            end else if (en) begin
                cycle <= (cycle == CYC_3) ? CYC_NONE : cycle + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_rd_seq.sv
// tb/tb_ldpc_rd_seq.sv - scoreboard bench for the LDPC read-address sequencer
module tb_ldpc_rd_seq;

    localparam int A_WID = 8;
    localparam int R_WID = 6;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [R_WID-1:0]   row_num = '0;
    logic               stall = 1'b0;
    logic               tbl_rd;
    logic [R_WID-1:0]   tbl_addr;
    logic [4*A_WID-1:0] tbl_data = '0;
    logic               en;
    logic [1:0]         cycle;
    logic [A_WID-1:0]   base_addr;
    logic [3*A_WID-1:0] addr_offset;
    logic [R_WID-1:0]   row_idx;
    logic               busy;
    logic               done;

    ldpc_rd_seq #(
        .A_WID (A_WID),
        .R_WID (R_WID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .row_num     (row_num),
        .stall       (stall),
        .tbl_rd      (tbl_rd),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .en          (en),
        .cycle       (cycle),
        .base_addr   (base_addr),
        .addr_offset (addr_offset),
        .row_idx     (row_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-written matrix table; unlisted rows hold a poison pattern.
    logic [31:0] ent [64];
    initial begin
        for (int i = 0; i < 64; i++) ent[i] = 32'hDEADBEEF;
        ent[0] = 32'h10010203;
        ent[1] = 32'h30020304;
        ent[2] = 32'h50030405;
        ent[3] = 32'h70040506;
    end

    // Table RAM: data valid exactly one cycle after the strobe, garbage otherwise.
    always @(posedge clk) tbl_data <= tbl_rd ? ent[tbl_addr] : 32'hA5A5A5A5;

    int errors = 0;
    int checks = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    logic [39:0]      beat_q [$];
    logic [R_WID-1:0] addr_q [$];
    logic             logging = 1'b0;
    int               t0 = 0;
    int               rel;
    logic [31:0]      en_log, rd_log, done_log, busy_log;
    logic [1:0]       cyc_log [32];

    // Monitor: log waveform bits per relative cycle and score every beat and table read.
    always @(negedge clk) begin
        rel = cyc - t0;
        if (logging && rel >= 0 && rel < 32) begin
            en_log[rel]   = en;
            rd_log[rel]   = tbl_rd;
            done_log[rel] = done;
            busy_log[rel] = busy;
            cyc_log[rel]  = cycle;
        end
        if (logging && en) begin
            if (beat_q.size() == 0) check("beat_extra", 64'(row_idx), 64'hFFFF);
            else check("beat", 64'({row_idx, cycle, base_addr, addr_offset}), 64'(beat_q.pop_front()));
        end
        if (logging && tbl_rd) begin
            if (addr_q.size() == 0) check("rd_extra", 64'(tbl_addr), 64'hFFFF);
            else check("tbl_addr", 64'(tbl_addr), 64'(addr_q.pop_front()));
        end
    end

    task automatic run_pass(input int n, input int stall_rel, input int restart_rel);
        en_log = '0; rd_log = '0; done_log = '0; busy_log = '0;
        for (int i = 0; i < 32; i++) cyc_log[i] = 2'd0;
        for (int r = 0; r < n; r++) begin
            for (int c = 1; c <= 3; c++) beat_q.push_back({6'(r), 2'(c), ent[r]});
            addr_q.push_back(6'(r));
        end
        @(posedge clk); #1;
        row_num = 6'(n);
        start   = 1'b1;
        t0      = cyc;
        logging = 1'b1;
        @(posedge clk); #1;
        row_num = 6'd7;
        while (cyc - t0 < 16) begin
            stall = (cyc - t0 == stall_rel || cyc - t0 == stall_rel + 1);
            start = (cyc - t0 == restart_rel);
            @(posedge clk); #1;
        end
        stall   = 1'b0;
        start   = 1'b0;
        row_num = '0;
        logging = 1'b0;
        check("beats_left", 64'(beat_q.size()), 64'd0);
        check("reads_left", 64'(addr_q.size()), 64'd0);
        beat_q.delete();
        addr_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({tbl_rd, tbl_addr, en, cycle, base_addr, addr_offset, row_idx, busy, done}), 64'd0);
        reset = 1'b0;

        // 1: async reset in the middle of RUN
        @(posedge clk); #1;
        row_num = 6'd2;
        start   = 1'b1;
        t0      = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t1_en_before_rst", 64'(en), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t1_async_rst", 64'({tbl_rd, tbl_addr, en, cycle, base_addr, addr_offset, row_idx, busy, done}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_pass(2, -10, -10);
        check("t1_rd", 64'(rd_log), 64'h12);
        check("t1_en", 64'(en_log), 64'h1F8);
        check("t1_done", 64'(done_log), 64'h200);

        // 2: single row
        run_pass(1, -10, -10);
        check("t2_rd", 64'(rd_log), 64'h2);
        check("t2_en", 64'(en_log), 64'h38);
        check("t2_done", 64'(done_log), 64'h40);
        check("t2_busy", 64'(busy_log), 64'h3E);
        check("t2_cyc3", 64'(cyc_log[5]), 64'd3);

        // 3: three rows back to back
        run_pass(3, -10, -10);
        check("t3_rd", 64'(rd_log), 64'h92);
        check("t3_en", 64'(en_log), 64'hFF8);
        check("t3_done", 64'(done_log), 64'h1000);
        check("t3_busy", 64'(busy_log), 64'hFFE);

        // 4: stall over row-0 cycle 3 while prefetch data lands
        run_pass(2, 5, -10);
        check("t4_rd", 64'(rd_log), 64'h12);
        check("t4_en", 64'(en_log), 64'h798);
        check("t4_en_count", 64'($countones(en_log)), 64'd6);
        check("t4_stall_cyc_a", 64'(cyc_log[5]), 64'd3);
        check("t4_stall_cyc_b", 64'(cyc_log[6]), 64'd3);
        check("t4_done", 64'(done_log), 64'h800);

        // 5: empty pass
        run_pass(0, -10, -10);
        check("t5_done", 64'(done_log), 64'h2);
        check("t5_quiet", 64'({rd_log, en_log}), 64'd0);
        check("t5_busy", 64'(busy_log), 64'd0);

        // 6: start pulsed during RUN is ignored
        run_pass(2, -10, 4);
        check("t6_rd", 64'(rd_log), 64'h12);
        check("t6_en", 64'(en_log), 64'h1F8);
        check("t6_done", 64'(done_log), 64'h200);
        check("t6_busy", 64'(busy_log), 64'h1FE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ldpc_rd_seq.md
Name: ldpc_rd_seq

Overview:
- Read-address sequencer that sits directly upstream of the per-cell read address generator (rd_cell).
- Walks the rows of the parity-check matrix. For each row it fetches a packed entry from a matrix table: one base address and three offsets.
- It then presents that entry for three consecutive cycles with cycle = 1, 2, 3 and en high, so the downstream cell forms base_addr + offset[cycle].
- It prefetches the next row during the current one, so back-to-back rows have no bubbles.

Parameters:
- A_WID, 8: address/offset width; must match the downstream address generator.
- R_WID, 6: row index width; up to 2^R_WID-1 rows per pass.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  start-pass pulse; accepted only in IDLE
- row_num  in  R_WID  rows in the pass; sampled with start
- stall  in  1  freezes sequencing while high
- tbl_rd  out  1  table read strobe
- tbl_addr  out  R_WID  table row address
- tbl_data  in  4*A_WID  entry packing: [4A-1:3A] base, [3A-1:2A] off1, [2A-1:A] off2, [A-1:0] off3; valid exactly 1 cycle after tbl_rd
- en  out  1  address-generate enable to the downstream cell
- cycle  out  2  sub-cycle: 1, 2, 3; 0 outside RUN
- base_addr  out  A_WID  current row base
- addr_offset  out  3*A_WID  current offsets, off1 in the MSBs, off3 in the LSBs
- row_idx  out  R_WID  row currently presented
- busy  out  1  pass in progress
- done  out  1  one-cycle end-of-pass pulse

Behaviour:
- Reset (async, active-high): state IDLE. Every output resets to 0. Shadow registers and all counters reset to 0.
- States: IDLE, FETCH, WAIT, RUN, DONE.
- IDLE
  - start=1 with row_num!=0: latch row_num, clear row counter, go to FETCH.
  - start=1 with row_num=0: go to DONE.
  - stall is ignored in IDLE.
- FETCH: tbl_rd=1, tbl_addr=0, then go to WAIT. If stall is high, hold in FETCH with tbl_rd=0.
- WAIT: tbl_data is valid. Load the working registers, then go to RUN with cycle=1. Stall holds the state.
- RUN
  - en=1 and cycle steps 1→2→3. base_addr, addr_offset and row_idx are held stable for all three cycles.
  - At cycle=2, when row_idx+1 < row_num: tbl_rd=1 and tbl_addr=row_idx+1 (prefetch).
  - At cycle=3, if more rows remain: load the working registers, row_idx+1, cycle=1. Otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- busy is 1 in FETCH, WAIT and RUN only.
- Latency: start at T0 → tbl_rd at T1 → en first high at T3. Throughput is 3 cycles per row.
- Prefetch capture:
  - rd_vld_d is tbl_rd delayed one cycle.
  - The shadow register captures tbl_data whenever rd_vld_d=1, regardless of stall.
  - A working-register load takes tbl_data if rd_vld_d=1, else the shadow register.
  - Consequence: prefetched data that arrives during a stall is never lost.
- Stall in FETCH, WAIT or RUN:
  - State, cycle, row_idx and the working registers all freeze.
  - en=0 and tbl_rd=0.
  - A prefetch whose cycle=2 slot is stalled is issued on the first unstalled cycle=2 cycle.
- start while busy or in DONE: ignored.
- row_idx and tbl_addr never exceed row_num-1. No wrap-around occurs within a pass.

Decomposition:
- Shared package ldpc_rd_pkg holds:
  - the state encoding;
  - the cycle constants CYC_NONE=0, CYC_1=1, CYC_2=2, CYC_3=3;
  - localparams for the tbl_data field slices, which are also used by the table generator.
- One natural sub-module, ldpc_rd_prefetch: rd_vld_d, the shadow register and the load mux.

Test Plan:
1. Reset assertion mid-RUN → all outputs 0 immediately, without a clock. After release, start with row_num=2 runs from row 0.
2. row_num=1, entry0 = {0x10,0x01,0x02,0x03}, start at T0:
   - tbl_rd at T1 with tbl_addr=0;
   - T3–T5: en=1, cycle=1,2,3, base_addr=0x10, addr_offset=0x010203;
   - done at T6; busy high T1–T5;
   - no second tbl_rd.
3. row_num=3, distinct entries:
   - tbl_rd at T1, T4, T7 with addresses 0, 1, 2; none at T10;
   - en high continuously T3–T11; row_idx changes at T6 and T9; done at T12.
4. row_num=2, stall high for 2 cycles starting at row 0 cycle=3 (prefetch data arrives while stalled):
   - en=0 and cycle held at 3 for both stalled cycles;
   - after the stall, cycle=3 with row-0 values, then row-1 values correct;
   - total en-high cycles = 6.
5. row_num=0 → done the cycle after start; no tbl_rd, en or busy ever asserted.
6. start pulsed again during RUN → no effect; the pass completes with a single done pulse.
